// File: rtl/stage_wb_if.sv
// MEM-to-WB handshake and register-file write bus for the write-back stage.
// master = upstream/memory side, slave = the write-back stage itself.
interface stage_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OFF_W  = $clog2(DATA_W / 8)
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [ADDR_W-1:0] rd_waddr_i;
    logic              rd_wena_i;
    logic [1:0]        wb_sel_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] link_addr_i;
    logic [DATA_W-1:0] aux_data_i;
    logic [1:0]        mem_size_i;
    logic              mem_unsigned_i;
    logic [OFF_W-1:0]  mem_offset_i;
    logic              dmem_rvalid_i;
    logic [DATA_W-1:0] dmem_rdata_i;
    logic              flush_i;
    logic [ADDR_W-1:0] rd_waddr_o;
    logic              rd_wena_o;
    logic [DATA_W-1:0] rd_wdata_o;
    logic              stall_req_o;

    modport master (
        output in_valid_i, rd_waddr_i, rd_wena_i, wb_sel_i, alu_result_i,
               link_addr_i, aux_data_i, mem_size_i, mem_unsigned_i,
               mem_offset_i, dmem_rvalid_i, dmem_rdata_i, flush_i,
        input  in_ready_o, rd_waddr_o, rd_wena_o, rd_wdata_o, stall_req_o
    );

    modport slave (
        input  in_valid_i, rd_waddr_i, rd_wena_i, wb_sel_i, alu_result_i,
               link_addr_i, aux_data_i, mem_size_i, mem_unsigned_i,
               mem_offset_i, dmem_rvalid_i, dmem_rdata_i, flush_i,
        output in_ready_o, rd_waddr_o, rd_wena_o, rd_wdata_o, stall_req_o
    );
endinterface

// File: rtl/stage_wb_pipe.sv
// Write-back stage: selects the result source, aligns/extends loads, waits on
// slow memory responses and commits one instruction per cycle to the register file.
module stage_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic             clk,
    input  logic             rst,
    stage_wb_if.slave        bus,
    output logic             retire_o,
    output logic [CNT_W-1:0] retire_cnt_o
);
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [1:0] SEL_MEM  = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
    localparam logic [OFF_W-1:0] WORD_MASK = (DATA_W == 64) ? OFF_W'(4) : '0;

    state_t            state;
    logic [ADDR_W-1:0] cap_waddr;
    logic              cap_wena;
    logic [1:0]        cap_size;
    logic              cap_unsigned;
    logic [OFF_W-1:0]  cap_offset;

    logic              idle, accept, commit, go_wait;
    logic [ADDR_W-1:0] cur_waddr;
    logic              cur_wena;
    logic [1:0]        cur_sel;
    logic [1:0]        cur_size;
    logic              cur_unsigned;
    logic [OFF_W-1:0]  cur_offset;
    logic [OFF_W-1:0]  lane_off;
    logic [DATA_W-1:0] lane, keep_mask, load_data, wb_data;
    logic              sign_bit;

    // In IDLE the instruction is taken straight from the inputs; in WAIT from the capture.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        idle         = (state == ST_IDLE);
        accept       = idle && bus.in_valid_i && !bus.flush_i;
        go_wait      = accept && (bus.wb_sel_i == SEL_MEM) && !bus.dmem_rvalid_i;
        cur_waddr    = idle ? bus.rd_waddr_i     : cap_waddr;
        cur_wena     = idle ? bus.rd_wena_i      : cap_wena;
        cur_sel      = idle ? bus.wb_sel_i       : SEL_MEM;
        cur_size     = idle ? bus.mem_size_i     : cap_size;
        cur_unsigned = idle ? bus.mem_unsigned_i : cap_unsigned;
        cur_offset   = idle ? bus.mem_offset_i   : cap_offset;
        commit       = idle ? (accept && (bus.wb_sel_i != SEL_MEM || bus.dmem_rvalid_i))
                            : (bus.dmem_rvalid_i && !bus.flush_i);
    end

    // Little-endian lane extraction; a 32-bit "double" collapses to a word.
    always_comb begin
        lane_off = '0;
        case (cur_size)
            2'b00:   lane_off = cur_offset;
            2'b01:   lane_off = cur_offset & HALF_MASK;
            2'b10:   lane_off = cur_offset & WORD_MASK;
            default: lane_off = '0;
        endcase
        lane = bus.dmem_rdata_i >> {lane_off, 3'b000};

        keep_mask = '1;
        sign_bit  = 1'b0;
        case (cur_size)
            2'b00: begin keep_mask = DATA_W'(8'hFF);   sign_bit = lane[7];  end
            2'b01: begin keep_mask = DATA_W'(16'hFFFF); sign_bit = lane[15]; end
            2'b10: if (DATA_W == 64) begin
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = lane[31];
            end
            default: ;
        endcase
        load_data = (lane & keep_mask) | ((!cur_unsigned && sign_bit) ? ~keep_mask : '0);

        case (cur_sel)
            SEL_MEM:  wb_data = load_data;
            SEL_ALU:  wb_data = bus.alu_result_i;
            SEL_LINK: wb_data = bus.link_addr_i;
            default:  wb_data = bus.aux_data_i;
        endcase
    end

    assign bus.in_ready_o  = idle && !rst;
    assign bus.stall_req_o = (state == ST_WAIT);

    // NOTE: all state here uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cap_waddr      <= '0;
            cap_wena       <= 1'b0;
            cap_size       <= '0;
            cap_unsigned   <= 1'b0;
            cap_offset     <= '0;
            bus.rd_waddr_o <= '0;
            bus.rd_wena_o  <= 1'b0;
            bus.rd_wdata_o <= '0;
            retire_o       <= 1'b0;
            retire_cnt_o   <= '0;
        end else begin
            bus.rd_wena_o <= 1'b0;
            retire_o      <= 1'b0;
            if (commit) begin
                bus.rd_waddr_o <= cur_waddr;
                bus.rd_wdata_o <= wb_data;
                bus.rd_wena_o  <= cur_wena && (cur_waddr != '0);
                retire_o       <= 1'b1;
                retire_cnt_o   <= retire_cnt_o + CNT_W'(1);
            end
            case (state)
                ST_IDLE: if (go_wait) begin
                    state        <= ST_WAIT;
                    cap_waddr    <= bus.rd_waddr_i;
                    cap_wena     <= bus.rd_wena_i;
                    cap_size     <= bus.mem_size_i;
                    cap_unsigned <= bus.mem_unsigned_i;
                    cap_offset   <= bus.mem_offset_i;
                end
                ST_WAIT: if (bus.flush_i || bus.dmem_rvalid_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_wb_pipe.sv
// Directed bench for stage_wb_pipe; a second instance with a 4-bit counter
// shadows the same stimulus so counter wrap-around is reachable quickly.
module tb_stage_wb_pipe;
    logic        clk;
    logic        rst;
    logic        retire, retire_w;
    logic [31:0] retire_cnt;
    logic [3:0]  retire_cnt_w;
    int          vectors = 0;
    int          miscompares = 0;

    stage_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    stage_wb_if #(.DATA_W(32), .ADDR_W(5)) bus_w ();

    stage_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .retire_o(retire), .retire_cnt_o(retire_cnt)
    );
    stage_wb_pipe #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w), .retire_o(retire_w), .retire_cnt_o(retire_cnt_w)
    );

    assign bus_w.in_valid_i     = bus.in_valid_i;
    assign bus_w.rd_waddr_i     = bus.rd_waddr_i;
    assign bus_w.rd_wena_i      = bus.rd_wena_i;
    assign bus_w.wb_sel_i       = bus.wb_sel_i;
    assign bus_w.alu_result_i   = bus.alu_result_i;
    assign bus_w.link_addr_i    = bus.link_addr_i;
    assign bus_w.aux_data_i     = bus.aux_data_i;
    assign bus_w.mem_size_i     = bus.mem_size_i;
    assign bus_w.mem_unsigned_i = bus.mem_unsigned_i;
    assign bus_w.mem_offset_i   = bus.mem_offset_i;
    assign bus_w.dmem_rvalid_i  = bus.dmem_rvalid_i;
    assign bus_w.dmem_rdata_i   = bus.dmem_rdata_i;
    assign bus_w.flush_i        = bus.flush_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_wb(input string tag, input logic wena, input logic [4:0] waddr,
                            input logic [31:0] wdata, input logic ret, input logic [31:0] cnt);
        check({tag, ".wena"},  32'(bus.rd_wena_o),  32'(wena));
        check({tag, ".waddr"}, 32'(bus.rd_waddr_o), 32'(waddr));
        check({tag, ".wdata"}, bus.rd_wdata_o,      wdata);
        check({tag, ".retire"}, 32'(retire),        32'(ret));
        check({tag, ".cnt"},   retire_cnt,          cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid_i     = 1'b0;
        bus.rd_waddr_i     = '0;
        bus.rd_wena_i      = 1'b0;
        bus.wb_sel_i       = 2'b00;
        bus.alu_result_i   = '0;
        bus.link_addr_i    = '0;
        bus.aux_data_i     = '0;
        bus.mem_size_i     = 2'b00;
        bus.mem_unsigned_i = 1'b0;
        bus.mem_offset_i   = '0;
        bus.dmem_rvalid_i  = 1'b0;
        bus.dmem_rdata_i   = '0;
        bus.flush_i        = 1'b0;
    endtask

    // Non-MEM source: the chosen source carries d, the others carry ~d.
    task automatic src_op(input logic [1:0] sel, input logic [4:0] wa, input logic we,
                          input logic [31:0] d);
        bus.in_valid_i   = 1'b1;
        bus.wb_sel_i     = sel;
        bus.rd_waddr_i   = wa;
        bus.rd_wena_i    = we;
        bus.alu_result_i = (sel == 2'b01) ? d : ~d;
        bus.link_addr_i  = (sel == 2'b10) ? d : ~d;
        bus.aux_data_i   = (sel == 2'b11) ? d : ~d;
        step();
        idle_inputs();
    endtask

    task automatic load_op(input logic [4:0] wa, input logic [1:0] size, input logic uns,
                           input logic [1:0] off, input logic rvalid, input logic [31:0] rdata);
        bus.in_valid_i     = 1'b1;
        bus.wb_sel_i       = 2'b00;
        bus.rd_waddr_i     = wa;
        bus.rd_wena_i      = 1'b1;
        bus.alu_result_i   = 32'h5555_5555;
        bus.mem_size_i     = size;
        bus.mem_unsigned_i = uns;
        bus.mem_offset_i   = off;
        bus.dmem_rvalid_i  = rvalid;
        bus.dmem_rdata_i   = rdata;
        step();
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #12;
        check_wb("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        check("reset.stall", 32'(bus.stall_req_o), 32'd0);
        check("reset.ready", 32'(bus.in_ready_o), 32'd0);
        rst = 1'b0;
        #1;
        check("release.ready", 32'(bus.in_ready_o), 32'd1);
        step();

        src_op(2'b01, 5'd3, 1'b1, 32'h1234_5678);
        check_wb("alu_r3", 1'b1, 5'd3, 32'h1234_5678, 1'b1, 32'd1);
        step();
        check_wb("alu_hold", 1'b0, 5'd3, 32'h1234_5678, 1'b0, 32'd1);

        load_op(5'd5, 2'b00, 1'b0, 2'd2, 1'b1, 32'h00AB_0000);
        check_wb("lb_s_off2", 1'b1, 5'd5, 32'hFFFF_FFAB, 1'b1, 32'd2);
        load_op(5'd5, 2'b00, 1'b1, 2'd2, 1'b1, 32'h00AB_0000);
        check_wb("lbu_off2", 1'b1, 5'd5, 32'h0000_00AB, 1'b1, 32'd3);
        load_op(5'd6, 2'b01, 1'b0, 2'd2, 1'b1, 32'h8001_0000);
        check_wb("lh_s_off2", 1'b1, 5'd6, 32'hFFFF_8001, 1'b1, 32'd4);
        load_op(5'd6, 2'b00, 1'b0, 2'd3, 1'b1, 32'h7F00_0000);
        check_wb("lb_s_pos_off3", 1'b1, 5'd6, 32'h0000_007F, 1'b1, 32'd5);
        load_op(5'd6, 2'b01, 1'b0, 2'd1, 1'b1, 32'h0000_8ABC);
        check_wb("lh_off1_bit0_ignored", 1'b1, 5'd6, 32'hFFFF_8ABC, 1'b1, 32'd6);
        load_op(5'd6, 2'b10, 1'b0, 2'd1, 1'b1, 32'hDEAD_BEEF);
        check_wb("lw_passthru", 1'b1, 5'd6, 32'hDEAD_BEEF, 1'b1, 32'd7);
        load_op(5'd6, 2'b11, 1'b1, 2'd3, 1'b1, 32'h8000_0001);
        check_wb("ld_as_word", 1'b1, 5'd6, 32'h8000_0001, 1'b1, 32'd8);

        load_op(5'd7, 2'b10, 1'b0, 2'd0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wait%0d.stall", i), 32'(bus.stall_req_o), 32'd1);
            check($sformatf("wait%0d.ready", i), 32'(bus.in_ready_o), 32'd0);
            check($sformatf("wait%0d.retire", i), 32'(retire), 32'd0);
            if (i < 2) step();
        end
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'hCAFE_F00D;
        step();
        idle_inputs();
        check_wb("late_commit", 1'b1, 5'd7, 32'hCAFE_F00D, 1'b1, 32'd9);
        check("late_commit.ready", 32'(bus.in_ready_o), 32'd1);
        check("late_commit.stall", 32'(bus.stall_req_o), 32'd0);

        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h1111_1111;
        step();
        idle_inputs();
        check_wb("stray_rvalid", 1'b0, 5'd7, 32'hCAFE_F00D, 1'b0, 32'd9);

        src_op(2'b01, 5'd0, 1'b1, 32'h0000_0099);
        check_wb("r0_write", 1'b0, 5'd0, 32'h0000_0099, 1'b1, 32'd10);
        src_op(2'b10, 5'd9, 1'b0, 32'h0000_0400);
        check_wb("link_nowena", 1'b0, 5'd9, 32'h0000_0400, 1'b1, 32'd11);
        src_op(2'b11, 5'd4, 1'b1, 32'h0000_55AA);
        check_wb("aux", 1'b1, 5'd4, 32'h0000_55AA, 1'b1, 32'd12);

        bus.flush_i = 1'b1;
        src_op(2'b01, 5'd2, 1'b1, 32'h0000_0777);
        check_wb("flush_idle", 1'b0, 5'd4, 32'h0000_55AA, 1'b0, 32'd12);

        load_op(5'd8, 2'b10, 1'b0, 2'd0, 1'b0, 32'h0);
        check("flush_wait.pre_stall", 32'(bus.stall_req_o), 32'd1);
        bus.flush_i       = 1'b1;
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h0000_0BAD;
        step();
        idle_inputs();
        check_wb("flush_wait", 1'b0, 5'd4, 32'h0000_55AA, 1'b0, 32'd12);
        check("flush_wait.ready", 32'(bus.in_ready_o), 32'd1);
        check("flush_wait.stall", 32'(bus.stall_req_o), 32'd0);

        for (int i = 0; i < 3; i++) src_op(2'b01, 5'd1, 1'b1, 32'(i));
        check("wrap.main15", retire_cnt, 32'd15);
        check("wrap.small_all_ones", 32'(retire_cnt_w), 32'hF);
        src_op(2'b01, 5'd1, 1'b1, 32'h0000_00F0);
        check("wrap.main16", retire_cnt, 32'd16);
        check("wrap.small_zero", 32'(retire_cnt_w), 32'h0);
        check("wrap.small_retire", 32'(retire_w), 32'd1);
        check("wrap.small_wdata", bus_w.rd_wdata_o, 32'h0000_00F0);

        load_op(5'd10, 2'b10, 1'b0, 2'd0, 1'b0, 32'h0);
        check("arst.pre_stall", 32'(bus.stall_req_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_wb("arst", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        check("arst.stall", 32'(bus.stall_req_o), 32'd0);
        check("arst.ready", 32'(bus.in_ready_o), 32'd0);
        check("arst.small_cnt", 32'(retire_cnt_w), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("arst_release.ready", 32'(bus.in_ready_o), 32'd1);
        check("arst_release.stall", 32'(bus.stall_req_o), 32'd0);
        step();
        src_op(2'b01, 5'd3, 1'b1, 32'h0000_ABCD);
        check_wb("post_reset_alu", 1'b1, 5'd3, 32'h0000_ABCD, 1'b1, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stage_wb_pipe.md
Name: stage_wb_pipe

Overview:
- Parametrised write-back stage with its own MEM/WB pipeline register.
- Selects one of four write-back sources.
- Sign/zero-extends sub-word loads using the byte offset.
- Waits for a variable-latency data-memory response, stalling upstream while it waits.
- Suppresses writes to register 0 and counts retired instructions.
- Sits between the MEM stage and the register file.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- ADDR_W, 5, register-file address width.
- CNT_W, 32, retired-instruction counter width.
- OFF_W, $clog2(DATA_W/8), byte-offset width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid_i  in  1  upstream instruction valid.
- in_ready_o  out  1  stage can accept an instruction this cycle.
- rd_waddr_i  in  ADDR_W  destination register.
- rd_wena_i  in  1  instruction writes a register.
- wb_sel_i  in  2  source select: 00 MEM, 01 ALU, 10 LINK, 11 AUX.
- alu_result_i  in  DATA_W  ALU result.
- link_addr_i  in  DATA_W  return address (PC+8/PC+4).
- aux_data_i  in  DATA_W  HI/LO/CP0 read data.
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 double (legal only when DATA_W=64).
- mem_unsigned_i  in  1  1 = zero-extend, 0 = sign-extend.
- mem_offset_i  in  OFF_W  low address bits of the load.
- dmem_rvalid_i  in  1  memory read data valid.
- dmem_rdata_i  in  DATA_W  memory read data, naturally aligned bus word.
- flush_i  in  1  discard the pending or captured instruction.
- rd_waddr_o  out  ADDR_W  register-file write address.
- rd_wena_o  out  1  register-file write enable.
- rd_wdata_o  out  DATA_W  register-file write data.
- stall_req_o  out  1  waiting on memory; upstream must hold.
- retire_o  out  1  one-cycle pulse per committed instruction.
- retire_cnt_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, any state): state=IDLE. rd_waddr_o, rd_wena_o, rd_wdata_o, retire_o and retire_cnt_o are all 0. stall_req_o=0. in_ready_o=1 after deassertion.
- States:
  - IDLE: in_ready_o=1. Accept when in_valid_i=1 and flush_i=0.
  - WAIT: in_ready_o=0, stall_req_o=1. Holds the captured fields.
- Accept a non-MEM source, or a MEM source with dmem_rvalid_i=1 in the same cycle: commit at the next edge. Outputs are registered, so latency is 1 cycle from accept. Stay in IDLE.
- Accept a MEM source with dmem_rvalid_i=0: go to WAIT and latch the fields. When dmem_rvalid_i=1, commit at that edge and return to IDLE. The next accept is possible in the cycle after commit.
- Commit:
  - rd_waddr_o = captured address.
  - rd_wdata_o = selected, extended data.
  - rd_wena_o = rd_wena_i && (rd_waddr != 0).
  - retire_o=1 for one cycle.
  - retire_cnt_o increments by 1, wrapping at 2^CNT_W.
  - Instructions with rd_wena_i=0 still retire.
- Without a commit: rd_wena_o=0 and retire_o=0. rd_waddr_o and rd_wdata_o hold their last values.
- Load extraction is little-endian:
  - byte lane = offset.
  - half = offset with bit0 ignored.
  - word (DATA_W=64) = offset[2] selects the upper or lower word.
  - Word with DATA_W=32, and double, ignore offset.
- Extension: the lane is sign- or zero-extended to DATA_W. Word loads on a 32-bit datapath are passed through unchanged.
- mem_size_i=11 with DATA_W=32 is treated as word.
- flush_i=1:
  - In IDLE: no capture.
  - In WAIT: the pending load is dropped, no commit, return to IDLE next cycle.
  - flush_i wins over a simultaneous dmem_rvalid_i.
- dmem_rvalid_i while IDLE with no MEM accept is ignored.

Test Plan:
- ALU writes r3=0x1234_5678 with wb_sel=01 -> next cycle rd_wena_o=1, rd_waddr_o=3, rd_wdata_o=0x12345678, retire_o=1, retire_cnt_o=1.
- Byte load, signed, offset=2, rdata=0x00AB0000 -> rd_wdata_o=0xFFFFFFAB. Same with unsigned -> 0x000000AB. Half signed, offset=2, rdata=0x80010000 -> 0xFFFF8001.
- MEM load with rvalid delayed 3 cycles -> stall_req_o=1 and in_ready_o=0 for 3 cycles; commit on the rvalid edge; in_ready_o=1 the following cycle.
- Write to r0 with rd_wena_i=1 -> rd_wena_o=0, retire_o=1, counter increments.
- flush_i asserted in WAIT together with dmem_rvalid_i -> no write, no retire, back to IDLE. Counter preset to 0xFFFFFFFF then one retire -> 0.
- rst asserted mid-WAIT (asynchronous, between edges) -> all outputs 0 immediately; in_ready_o=1 after release.
